// File: rtl/asic_sprite_mixer.sv
// Pixel compositor: merges sprite and gate-array pixels, resolves them through the
// 32-entry 12-bit palette RAM and owns the clear-on-read sprite collision register.
module asic_sprite_mixer #(
    parameter logic [15:0] PAL_BASE  = 16'h6400,
    parameter logic [15:0] COLL_ADDR = 16'h6000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        plus_mode,
    input  logic        pix_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    input  logic [3:0]  bg_ink,
    input  logic        border,
    input  logic        hblank,
    input  logic        vblank,
    input  logic [7:0]  sprite_pixel,
    input  logic        sprite_active,
    input  logic [3:0]  sprite_id,
    output logic [11:0] rgb,
    output logic        hblank_o,
    output logic        vblank_o,
    output logic [7:0]  collision_flags
);

    // Palette entries are held as {R,G,B}
    logic [11:0] pal_q [32];

    logic [15:0] pal_off;
    logic        pal_hit;
    logic [4:0]  pal_entry;
    logic        pal_odd;
    logic [7:0]  pal_rd_byte;
    logic        coll_rd;

    assign pal_off     = cpu_addr - PAL_BASE;
    assign pal_hit     = (pal_off[15:6] == 10'd0);
    assign pal_entry   = pal_off[5:1];
    assign pal_odd     = pal_off[0];
    assign pal_rd_byte = pal_odd ? {4'h0, pal_q[pal_entry][7:4]}
                                 : {pal_q[pal_entry][11:8], pal_q[pal_entry][3:0]};
    assign coll_rd     = cpu_rd && (cpu_addr == COLL_ADDR);

    logic unused_bits;
    assign unused_bits = ^{sprite_pixel[7:4], sprite_id[3]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                pal_q[i] <= 12'h000;
            end
        end else if (cpu_wr && plus_mode && pal_hit) begin
            if (pal_odd) begin
                pal_q[pal_entry][7:4] <= cpu_data[3:0];
            end else begin
                pal_q[pal_entry][11:8] <= cpu_data[7:4];
                pal_q[pal_entry][3:0]  <= cpu_data[3:0];
            end
        end
    end

    // Stage 1: index selection and collision detection
    logic       blank_in;
    logic       spr_opaque;
    logic       coll_evt;
    logic [4:0] idx_d,    idx_q;
    logic       blank_d,  blank_q;
    logic       hb1_q,    vb1_q;
    logic       v1_q;
    logic [7:0] flags_d,  flags_q;

    always_comb begin
        blank_in   = hblank || vblank;
        spr_opaque = plus_mode && sprite_active && (sprite_pixel[3:0] != 4'h0);
        blank_d    = blank_in;
        if (blank_in) begin
            idx_d = 5'd0;
        end else if (border) begin
            idx_d = 5'd16;
        end else if (spr_opaque) begin
            idx_d = {1'b1, sprite_pixel[3:0]};
        end else begin
            idx_d = {1'b0, bg_ink};
        end
        coll_evt = pix_en && spr_opaque && !blank_in && !border && (bg_ink != 4'h0);
        // A set event on the clearing read survives: set is ORed in after the clear
        flags_d  = coll_rd ? 8'h00 : flags_q;
        if (coll_evt) begin
            flags_d = flags_d | (8'h01 << sprite_id[2:0]);
        end
    end

    // Stage 2: palette lookup and blank alignment
    logic [11:0] rgb_d, rgb_q;
    logic        hb2_q, vb2_q;
    logic [7:0]  dout_d, dout_q;

    always_comb begin
        rgb_d = (blank_q || !v1_q) ? 12'h000 : pal_q[idx_q];
        if (cpu_rd) begin
            if (coll_rd) begin
                dout_d = flags_q;
            end else if (pal_hit) begin
                dout_d = pal_rd_byte;
            end else begin
                dout_d = 8'h00;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            idx_q   <= 5'd0;
            blank_q <= 1'b0;
            hb1_q   <= 1'b0;
            vb1_q   <= 1'b0;
            v1_q    <= 1'b0;
            rgb_q   <= 12'h000;
            hb2_q   <= 1'b0;
            vb2_q   <= 1'b0;
            flags_q <= 8'h00;
            dout_q  <= 8'h00;
        end else begin
            if (pix_en) begin
                idx_q   <= idx_d;
                blank_q <= blank_d;
                hb1_q   <= hblank;
                vb1_q   <= vblank;
                v1_q    <= 1'b1;
                rgb_q   <= rgb_d;
                hb2_q   <= hb1_q;
                vb2_q   <= vb1_q;
            end
            flags_q <= flags_d;
            dout_q  <= dout_d;
        end
    end

    assign rgb             = rgb_q;
    assign hblank_o        = hb2_q;
    assign vblank_o        = vb2_q;
    assign collision_flags = flags_q;
    assign cpu_dout        = dout_q;

endmodule

// File: tb/tb_asic_sprite_mixer.sv
// Directed bench for asic_sprite_mixer: palette access, compositing priority,
// pipeline latency/enable, collision register and plus_mode gating.
module tb_asic_sprite_mixer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        plus_mode;
    logic        pix_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_dout;
    logic [3:0]  bg_ink;
    logic        border;
    logic        hblank;
    logic        vblank;
    logic [7:0]  sprite_pixel;
    logic        sprite_active;
    logic [3:0]  sprite_id;
    logic [11:0] rgb;
    logic        hblank_o;
    logic        vblank_o;
    logic [7:0]  collision_flags;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rd_val;

    asic_sprite_mixer dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .plus_mode       (plus_mode),
        .pix_en          (pix_en),
        .cpu_addr        (cpu_addr),
        .cpu_data        (cpu_data),
        .cpu_wr          (cpu_wr),
        .cpu_rd          (cpu_rd),
        .cpu_dout        (cpu_dout),
        .bg_ink          (bg_ink),
        .border          (border),
        .hblank          (hblank),
        .vblank          (vblank),
        .sprite_pixel    (sprite_pixel),
        .sprite_active   (sprite_active),
        .sprite_id       (sprite_id),
        .rgb             (rgb),
        .hblank_o        (hblank_o),
        .vblank_o        (vblank_o),
        .collision_flags (collision_flags)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_wr   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        tick();
        cpu_rd   = 1'b0;
        d        = cpu_dout;
    endtask

    task automatic test_reset();
        reset = 1'b1; plus_mode = 1'b1; pix_en = 1'b1; bg_ink = 4'd5; hblank = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h exp %h", rgb, 12'h000); end
        n_checks++; if (hblank_o !== 1'b0) begin n_fail++; $display("FAIL reset_hblank_o: got %b exp 0", hblank_o); end
        n_checks++; if (vblank_o !== 1'b0) begin n_fail++; $display("FAIL reset_vblank_o: got %b exp 0", vblank_o); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h exp 00", collision_flags); end
        n_checks++; if (cpu_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h exp 00", cpu_dout); end
        reset = 1'b0; hblank = 1'b0; bg_ink = 4'd0;
        cpu_read(16'h6400, rd_val);
        n_checks++; if (rd_val !== 8'h00) begin n_fail++; $display("FAIL reset_pal: got %h exp 00", rd_val); end
    endtask

    task automatic test_palette_basic();
        bg_ink = 4'd1;
        cpu_write(16'h6400, 8'hF0);
        cpu_write(16'h6401, 8'hFA);
        tick(); tick();
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL pal_pen1: got %h exp 000", rgb); end
        bg_ink = 4'd0;
        tick();
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL pal_beat1: got %h exp 000", rgb); end
        tick();
        n_checks++; if (rgb !== 12'hFA0) begin n_fail++; $display("FAIL pal_beat2: got %h exp FA0", rgb); end
        cpu_read(16'h6401, rd_val);
        n_checks++; if (rd_val !== 8'h0A) begin n_fail++; $display("FAIL pal_rd_odd: got %h exp 0A", rd_val); end
        cpu_read(16'h6440, rd_val);
        n_checks++; if (rd_val !== 8'h00) begin n_fail++; $display("FAIL rd_above: got %h exp 00", rd_val); end
        cpu_read(16'h6400, rd_val);
        n_checks++; if (rd_val !== 8'hF0) begin n_fail++; $display("FAIL pal_rd_even: got %h exp F0", rd_val); end
        cpu_read(16'h63FF, rd_val);
        n_checks++; if (rd_val !== 8'h00) begin n_fail++; $display("FAIL rd_below: got %h exp 00", rd_val); end
        cpu_read(16'h6400, rd_val);
        tick(); tick();
        n_checks++; if (cpu_dout !== 8'hF0) begin n_fail++; $display("FAIL dout_hold: got %h exp F0", cpu_dout); end
    endtask

    task automatic test_sprite();
        cpu_write(16'h6424, 8'h12);
        cpu_write(16'h6425, 8'h03);
        sprite_id = 4'd1; sprite_active = 1'b1; sprite_pixel = 8'h02; bg_ink = 4'd0;
        tick(); tick();
        n_checks++; if (rgb !== 12'h132) begin n_fail++; $display("FAIL spr_rgb: got %h exp 132", rgb); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL spr_nocoll_ink0: got %h exp 00", collision_flags); end
        bg_ink = 4'd5;
        tick();
        n_checks++; if (collision_flags !== 8'h02) begin n_fail++; $display("FAIL spr_coll: got %h exp 02", collision_flags); end
        tick();
        n_checks++; if (rgb !== 12'h132) begin n_fail++; $display("FAIL spr_rgb_ink5: got %h exp 132", rgb); end
        sprite_id = 4'd6; sprite_pixel = 8'h20;
        tick(); tick();
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL spr_transparent: got %h exp 000", rgb); end
        n_checks++; if (collision_flags !== 8'h02) begin n_fail++; $display("FAIL spr_transp_nocoll: got %h exp 02", collision_flags); end
        sprite_active = 1'b0;
        cpu_read(16'h6000, rd_val);
        n_checks++; if (rd_val !== 8'h02) begin n_fail++; $display("FAIL spr_coll_rd: got %h exp 02", rd_val); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL spr_coll_clr: got %h exp 00", collision_flags); end
    endtask

    task automatic test_collision();
        sprite_id = 4'd3; sprite_pixel = 8'h02; bg_ink = 4'd7; sprite_active = 1'b1;
        tick();
        sprite_active = 1'b0;
        n_checks++; if (collision_flags !== 8'h08) begin n_fail++; $display("FAIL coll_set: got %h exp 08", collision_flags); end
        tick();
        n_checks++; if (collision_flags !== 8'h08) begin n_fail++; $display("FAIL coll_sticky: got %h exp 08", collision_flags); end
        sprite_id = 4'd1; sprite_active = 1'b1;
        tick();
        sprite_active = 1'b0;
        n_checks++; if (collision_flags !== 8'h0A) begin n_fail++; $display("FAIL coll_accum: got %h exp 0A", collision_flags); end
        cpu_read(16'h6000, rd_val);
        n_checks++; if (rd_val !== 8'h0A) begin n_fail++; $display("FAIL coll_rd: got %h exp 0A", rd_val); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL coll_clr: got %h exp 00", collision_flags); end
        sprite_id = 4'd0; sprite_active = 1'b1;
        tick();
        sprite_id = 4'd3; cpu_addr = 16'h6000; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0; sprite_active = 1'b0;
        n_checks++; if (cpu_dout !== 8'h01) begin n_fail++; $display("FAIL coll_coinc_rd: got %h exp 01", cpu_dout); end
        n_checks++; if (collision_flags !== 8'h08) begin n_fail++; $display("FAIL coll_set_wins: got %h exp 08", collision_flags); end
        cpu_read(16'h6000, rd_val);
        n_checks++; if (rd_val !== 8'h08) begin n_fail++; $display("FAIL coll_rd2: got %h exp 08", rd_val); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL coll_clr2: got %h exp 00", collision_flags); end
    endtask

    task automatic test_blank_border();
        bg_ink = 4'd0;
        tick(); tick();
        n_checks++; if (rgb !== 12'hFA0) begin n_fail++; $display("FAIL blank_pre: got %h exp FA0", rgb); end
        hblank = 1'b1;
        tick();
        n_checks++; if (rgb !== 12'hFA0 || hblank_o !== 1'b0) begin n_fail++; $display("FAIL hblank_beat1: got %h/%b exp FA0/0", rgb, hblank_o); end
        tick();
        n_checks++; if (rgb !== 12'h000 || hblank_o !== 1'b1) begin n_fail++; $display("FAIL hblank_beat2: got %h/%b exp 000/1", rgb, hblank_o); end
        hblank = 1'b0; vblank = 1'b1;
        tick(); tick();
        n_checks++; if (rgb !== 12'h000 || vblank_o !== 1'b1 || hblank_o !== 1'b0) begin n_fail++; $display("FAIL vblank: got %h/%b/%b exp 000/1/0", rgb, vblank_o, hblank_o); end
        vblank = 1'b0;
        cpu_write(16'h6420, 8'h0F);
        cpu_write(16'h6421, 8'h00);
        border = 1'b1;
        tick(); tick();
        n_checks++; if (rgb !== 12'h00F || vblank_o !== 1'b0) begin n_fail++; $display("FAIL border: got %h/%b exp 00F/0", rgb, vblank_o); end
        sprite_active = 1'b1; sprite_id = 4'd2; sprite_pixel = 8'h02; bg_ink = 4'd7;
        tick(); tick();
        n_checks++; if (rgb !== 12'h00F) begin n_fail++; $display("FAIL border_over_sprite: got %h exp 00F", rgb); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL border_nocoll: got %h exp 00", collision_flags); end
        border = 1'b0; sprite_active = 1'b0; bg_ink = 4'd0;
        tick(); tick();
    endtask

    task automatic test_pix_en();
        cpu_write(16'h6404, 8'h5A);
        cpu_write(16'h6405, 8'h06);
        pix_en = 1'b1; bg_ink = 4'd0;
        tick(); tick();
        n_checks++; if (rgb !== 12'hFA0) begin n_fail++; $display("FAIL en_pre: got %h exp FA0", rgb); end
        bg_ink = 4'd2;
        pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rgb !== 12'hFA0) begin n_fail++; $display("FAIL en_hold0[%0d]: got %h exp FA0", i, rgb); end
        end
        pix_en = 1'b1;
        tick();
        n_checks++; if (rgb !== 12'hFA0) begin n_fail++; $display("FAIL en_beat1: got %h exp FA0", rgb); end
        pix_en = 1'b0; bg_ink = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rgb !== 12'hFA0) begin n_fail++; $display("FAIL en_hold1[%0d]: got %h exp FA0", i, rgb); end
        end
        pix_en = 1'b1;
        tick();
        n_checks++; if (rgb !== 12'h56A) begin n_fail++; $display("FAIL en_beat2: got %h exp 56A", rgb); end
        pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rgb !== 12'h56A) begin n_fail++; $display("FAIL en_hold2[%0d]: got %h exp 56A", i, rgb); end
        end
        pix_en = 1'b1;
        tick();
        n_checks++; if (rgb !== 12'hFA0) begin n_fail++; $display("FAIL en_beat3: got %h exp FA0", rgb); end
    endtask

    task automatic test_plus_off_and_reset();
        cpu_write(16'h6406, 8'h70);
        cpu_write(16'h6407, 8'h0C);
        plus_mode = 1'b0;
        cpu_write(16'h6400, 8'h00);
        cpu_write(16'h6406, 8'hFF);
        cpu_read(16'h6400, rd_val);
        n_checks++; if (rd_val !== 8'hF0) begin n_fail++; $display("FAIL off_frozen0: got %h exp F0", rd_val); end
        cpu_read(16'h6406, rd_val);
        n_checks++; if (rd_val !== 8'h70) begin n_fail++; $display("FAIL off_frozen3: got %h exp 70", rd_val); end
        sprite_id = 4'd5; sprite_active = 1'b1; sprite_pixel = 8'h02; bg_ink = 4'd3;
        tick(); tick();
        n_checks++; if (rgb !== 12'h7C0) begin n_fail++; $display("FAIL off_no_sprite: got %h exp 7C0", rgb); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL off_no_coll: got %h exp 00", collision_flags); end
        plus_mode = 1'b1; sprite_id = 4'd4;
        tick(); tick();
        n_checks++; if (rgb !== 12'h132 || collision_flags !== 8'h10) begin n_fail++; $display("FAIL on_again: got %h/%h exp 132/10", rgb, collision_flags); end
        reset = 1'b1;
        tick();
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL midreset_rgb: got %h exp 000", rgb); end
        n_checks++; if (collision_flags !== 8'h00) begin n_fail++; $display("FAIL midreset_flags: got %h exp 00", collision_flags); end
        reset = 1'b0; sprite_active = 1'b0; bg_ink = 4'd0;
        cpu_read(16'h6400, rd_val);
        n_checks++; if (rd_val !== 8'h00) begin n_fail++; $display("FAIL midreset_pal: got %h exp 00", rd_val); end
    endtask

    initial begin
        reset = 1'b1; plus_mode = 1'b0; pix_en = 1'b0;
        cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
        bg_ink = 4'd0; border = 1'b0; hblank = 1'b0; vblank = 1'b0;
        sprite_pixel = 8'h00; sprite_active = 1'b0; sprite_id = 4'd0;
        test_reset();
        test_palette_basic();
        test_sprite();
        test_collision();
        test_blank_border();
        test_pix_en();
        test_plus_off_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
